load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 159 +++++++++++++++
 tb/tb_load_store_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: byte/halfword/word accesses to a word-wide data memory, sub-word stores via
// read-modify-write. Define LSU_MISALIGN_EXC_EN to reject misaligned H/HU/W accesses.
module load_store_unit #(
   parameter int unsigned DMEM_WORDS = 16384
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [31:0] mem_A,
   output logic [31:0] mem_WD,
   output logic        mem_WE,
   input  logic [31:0] mem_RD
);

   typedef enum logic [2:0] {StIdle, StLoad, StRmwRd, StWrite, StResp} state_e;

   localparam logic [2:0] F3B  = 3'b000;
   localparam logic [2:0] F3H  = 3'b001;
   localparam logic [2:0] F3W  = 3'b010;
   localparam logic [2:0] F3BU = 3'b100;
   localparam logic [2:0] F3HU = 3'b101;

   state_e      state_q, state_d;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [2:0]  funct3_q;
   logic        we_q;
   logic [31:0] word_q;
   logic        accept;
   logic        req_err;
   logic [31:0] load_ext;
   logic [31:0] merged;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   assign accept = req_valid && (state_q == StIdle);

   always_comb begin
      req_err = 1'b0;
      unique case (req_funct3)
         F3B, F3H, F3W: req_err = 1'b0;
         F3BU, F3HU:    req_err = req_we;
         default:       req_err = 1'b1;
      endcase
      if ({2'b00, req_addr[31:2]} >= DMEM_WORDS) req_err = 1'b1;
`ifdef LSU_MISALIGN_EXC_EN
      if ((req_funct3 == F3H || req_funct3 == F3HU) && req_addr[0]) req_err = 1'b1;
      if (req_funct3 == F3W && req_addr[1:0] != 2'b00) req_err = 1'b1;
`endif
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= StIdle;
      else        state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (req_err)                state_d = StResp;
               else if (!req_we)           state_d = StLoad;
               else if (req_funct3 == F3W) state_d = StWrite;
               else                        state_d = StRmwRd;
            end
         end
         StLoad:  state_d = StResp;
         StRmwRd: state_d = StWrite;
         StWrite: state_d = StResp;
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Lane extraction; with misalignment tolerated, addr[0] is ignored for halfwords
   always_comb begin
      lane_b = 8'h00;
      unique case (addr_q[1:0])
         2'd0: lane_b = mem_RD[7:0];
         2'd1: lane_b = mem_RD[15:8];
         2'd2: lane_b = mem_RD[23:16];
         2'd3: lane_b = mem_RD[31:24];
         default: lane_b = 8'h00;
      endcase
      lane_h = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];
      load_ext = mem_RD;
      unique case (funct3_q)
         F3B:     load_ext = {{24{lane_b[7]}}, lane_b};
         F3H:     load_ext = {{16{lane_h[15]}}, lane_h};
         F3BU:    load_ext = {24'h0, lane_b};
         F3HU:    load_ext = {16'h0, lane_h};
         default: load_ext = mem_RD;
      endcase
   end

   always_comb begin
      merged = word_q;
      if (funct3_q == F3B) begin
         unique case (addr_q[1:0])
            2'd0: merged[7:0]   = wdata_q[7:0];
            2'd1: merged[15:8]  = wdata_q[7:0];
            2'd2: merged[23:16] = wdata_q[7:0];
            2'd3: merged[31:24] = wdata_q[7:0];
            default: merged = word_q;
         endcase
      end else if (addr_q[1]) begin
         merged[31:16] = wdata_q[15:0];
      end else begin
         merged[15:0] = wdata_q[15:0];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= 32'h0;
         wdata_q   <= 32'h0;
         funct3_q  <= 3'b000;
         we_q      <= 1'b0;
         word_q    <= 32'h0;
         rsp_rdata <= 32'h0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            addr_q   <= req_addr;
            wdata_q  <= req_wdata;
            funct3_q <= req_funct3;
            we_q     <= req_we;
         end
         if (state_q == StRmwRd) word_q <= mem_RD;
         // Response registers change only on entry to RESP so they hold between responses
         if (state_d == StResp && state_q != StResp) begin
            rsp_rdata <= (state_q == StLoad) ? load_ext : 32'h0;
            rsp_err   <= (state_q == StIdle);
         end
      end
   end

   // Output logic
   always_comb begin
      req_ready = (state_q == StIdle);
      rsp_valid = (state_q == StResp);
      mem_A     = {addr_q[31:2], 2'b00};
      mem_WE    = (state_q == StWrite) && we_q;
      mem_WD    = 32'h0;
      if (state_q == StWrite) mem_WD = (funct3_q == F3W) ? wdata_q : merged;
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed requests push expected responses and memory
// writes; a monitor pops and checks them, including cycle latency.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [2:0]  req_funct3 = 3'b000;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [31:0] mem_A;
   logic [31:0] mem_WD;
   logic        mem_WE;
   logic [31:0] mem_RD;

   load_store_unit #(.DMEM_WORDS(16384)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .mem_A(mem_A),
      .mem_WD(mem_WD), .mem_WE(mem_WE), .mem_RD(mem_RD)
   );

   always #5 clk = ~clk;

   logic [31:0] mem [0:16383];
   logic        pl_en = 1'b0;
   logic [13:0] pl_idx = 14'h0;
   logic [31:0] pl_data = 32'h0;

   assign mem_RD = mem[mem_A[15:2]];
   always @(posedge clk) begin
      if (mem_WE)     mem[mem_A[15:2]] <= mem_WD;
      else if (pl_en) mem[pl_idx] <= pl_data;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {logic [31:0] rdata; logic err; int cyc;} rsp_t;
   typedef struct {logic [31:0] a; logic [31:0] wd; int cyc;} wr_t;
   rsp_t rq[$];
   wr_t  wq[$];
   int n_checks = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor
   always @(negedge clk) begin
      if (rsp_valid) begin
         if (rq.size() == 0) chk("unexpected rsp_valid", 32'd1, 32'd0);
         else begin
            rsp_t e;
            e = rq.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_err", {31'h0, rsp_err}, {31'h0, e.err});
            chk("rsp cycle", cyc, e.cyc);
         end
      end
      if (mem_WE) begin
         if (wq.size() == 0) chk("unexpected mem_WE", 32'd1, 32'd0);
         else begin
            wr_t w;
            w = wq.pop_front();
            chk("mem_A", mem_A, w.a);
            chk("mem_WD", mem_WD, w.wd);
            chk("mem_WE cycle", cyc, w.cyc);
         end
      end
   end

   task automatic preload(input logic [13:0] idx, input logic [31:0] d);
      @(posedge clk); #1;
      pl_en = 1'b1; pl_idx = idx; pl_data = d;
      @(posedge clk); #1;
      pl_en = 1'b0;
   endtask

   // lat: accept-to-rsp_valid cycles; a store's write lands at lat-1
   task automatic lsu(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                      input int lat, input logic exp_wr, input logic [31:0] exp_wd);
      rsp_t r;
      wr_t  w;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wd;
      chk("req_ready idle", {31'h0, req_ready}, 32'd1);
      r.rdata = exp_rd; r.err = exp_err; r.cyc = cyc + lat;
      rq.push_back(r);
      if (exp_wr) begin
         w.a = {addr[31:2], 2'b00}; w.wd = exp_wd; w.cyc = cyc + lat - 1;
         wq.push_back(w);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (lat + 1) @(posedge clk);
      #1;
      chk("rsp outstanding", rq.size(), 0);
      chk("write outstanding", wq.size(), 0);
      rq.delete();
      wq.delete();
   endtask

   initial begin
      #2;
      chk("reset req_ready", {31'h0, req_ready}, 32'd1);
      chk("reset rsp_valid", {31'h0, rsp_valid}, 32'd0);
      chk("reset rsp_rdata", rsp_rdata, 32'h0);
      chk("reset rsp_err", {31'h0, rsp_err}, 32'd0);
      chk("reset mem_A", mem_A, 32'h0);
      chk("reset mem_WD", mem_WD, 32'h0);
      chk("reset mem_WE", {31'h0, mem_WE}, 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      preload(14'h800, 32'h0000000A);
      lsu(1'b0, 3'b010, 32'h2000, 32'h0, 32'h0000000A, 1'b0, 2, 1'b0, 32'h0);

      preload(14'h800, 32'h80FF7F01);
      lsu(1'b0, 3'b000, 32'h2001, 32'h0, 32'h0000007F, 1'b0, 2, 1'b0, 32'h0);
      lsu(1'b0, 3'b000, 32'h2003, 32'h0, 32'hFFFFFF80, 1'b0, 2, 1'b0, 32'h0);
      lsu(1'b0, 3'b101, 32'h2002, 32'h0, 32'h000080FF, 1'b0, 2, 1'b0, 32'h0);
      lsu(1'b0, 3'b001, 32'h2002, 32'h0, 32'hFFFF80FF, 1'b0, 2, 1'b0, 32'h0);
      lsu(1'b0, 3'b100, 32'h2003, 32'h0, 32'h00000080, 1'b0, 2, 1'b0, 32'h0);
      lsu(1'b0, 3'b001, 32'h2000, 32'h0, 32'h00007F01, 1'b0, 2, 1'b0, 32'h0);
      // Result must hold after the response pulse
      repeat (3) @(posedge clk);
      #1 chk("rsp_rdata hold", rsp_rdata, 32'h00007F01);

      preload(14'h800, 32'h11223344);
      lsu(1'b1, 3'b000, 32'h2002, 32'h000000AB, 32'h0, 1'b0, 3, 1'b1, 32'h11AB3344);
      lsu(1'b0, 3'b010, 32'h2000, 32'h0, 32'h11AB3344, 1'b0, 2, 1'b0, 32'h0);
      lsu(1'b1, 3'b001, 32'h2000, 32'h1234BEEF, 32'h0, 1'b0, 3, 1'b1, 32'h11ABBEEF);
      lsu(1'b1, 3'b001, 32'h2002, 32'h00005566, 32'h0, 1'b0, 3, 1'b1, 32'h5566BEEF);
      lsu(1'b1, 3'b010, 32'h2004, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, 32'hDEADBEEF);
      lsu(1'b0, 3'b010, 32'h2004, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0, 32'h0);

      // Address range boundary and illegal encodings
      lsu(1'b1, 3'b010, 32'h10000, 32'h12345678, 32'h0, 1'b1, 1, 1'b0, 32'h0);
      preload(14'h3FFF, 32'hCAFEF00D);
      lsu(1'b0, 3'b010, 32'hFFFC, 32'h0, 32'hCAFEF00D, 1'b0, 2, 1'b0, 32'h0);
      lsu(1'b0, 3'b011, 32'h2000, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0);
      lsu(1'b1, 3'b100, 32'h2000, 32'hFF, 32'h0, 1'b1, 1, 1'b0, 32'h0);
      lsu(1'b0, 3'b111, 32'h2000, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0);

      preload(14'h800, 32'h8001C002);
`ifdef LSU_MISALIGN_EXC_EN
      lsu(1'b0, 3'b010, 32'h2002, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0);
      lsu(1'b0, 3'b001, 32'h2001, 32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0);
      lsu(1'b1, 3'b001, 32'h2003, 32'h1111, 32'h0, 1'b1, 1, 1'b0, 32'h0);
`else
      lsu(1'b0, 3'b010, 32'h2002, 32'h0, 32'h8001C002, 1'b0, 2, 1'b0, 32'h0);
      lsu(1'b0, 3'b001, 32'h2001, 32'h0, 32'hFFFFC002, 1'b0, 2, 1'b0, 32'h0);
      lsu(1'b0, 3'b101, 32'h2003, 32'h0, 32'h00008001, 1'b0, 2, 1'b0, 32'h0);
`endif

      // Reset during RMW_RD of an SH: no write, no response
      preload(14'h800, 32'h11223344);
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b001; req_addr = 32'h2000;
      req_wdata = 32'h0000AAAA;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("rmw_rd not ready", {31'h0, req_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("mid-reset mem_WE", {31'h0, mem_WE}, 32'd0);
      chk("mid-reset req_ready", {31'h0, req_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (4) @(posedge clk);
      #1 chk("ready after release", {31'h0, req_ready}, 32'd1);
      lsu(1'b0, 3'b010, 32'h2000, 32'h0, 32'h11223344, 1'b0, 2, 1'b0, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
